dht_read_scheduler: RTL and testbench

- Sequences periodic reads of the DHT temperature/humidity sensor driver through its dht_en / dht_data_ready handshake.
- Applies a timeout, bounded retry with back-off, and a plausibility check to each read.
- Presents latched, validated readings with a one-cycle update strobe to the threshold/LCD logic.
- Sits between the DHT driver and the system logic controller; also accepts an on-demand read request (e.g. from a UART command).

---
 rtl/dht_read_scheduler.sv | 164 ++++++++++++++++
 tb/tb_dht_read_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dht_read_scheduler.sv
// Periodic / on-demand read sequencer for the DHT sensor driver, with timeout, bounded retry
// with back-off, plausibility checking, and latched validated readings.
module dht_read_scheduler #(
   parameter int unsigned PERIOD_CYCLES  = 200_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
   parameter int unsigned GAP_CYCLES     = 100_000_000,
   parameter int unsigned MAX_RETRY      = 2,
   parameter int unsigned TEMP_MAX       = 60,
   parameter int unsigned HUM_MAX        = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       force_read,
   output logic       dht_en,
   input  logic       dht_data_ready,
   input  logic       dht_error,
   input  logic [7:0] dht_temp_raw,
   input  logic [7:0] dht_hum_raw,
   output logic [7:0] temperature,
   output logic [7:0] humidity,
   output logic       sample_valid,
   output logic       data_stale,
   output logic       fault,
   output logic [7:0] fail_count
);

   localparam int unsigned PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [7:0] TempMaxB = 8'(TEMP_MAX);
   localparam logic [7:0] HumMaxB  = 8'(HUM_MAX);

   typedef enum logic [1:0] {StIdle, StReq, StBackoff, StFaultUpd} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] period_q, period_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          force_q, force_d;
   logic          dht_en_q, dht_en_d;
   logic [7:0]    temp_q, temp_d;
   logic [7:0]    hum_q, hum_d;
   logic          valid_q, valid_d;
   logic          stale_q, stale_d;
   logic          fault_q, fault_d;
   logic [7:0]    fail_q, fail_d;

   logic done, in_range, good, tmo_hit, failed;

   assign done     = (state_q == StReq) && dht_data_ready;
   assign in_range = (dht_temp_raw <= TempMaxB) && (dht_hum_raw <= HumMaxB);
   assign good     = done && !dht_error && in_range;
   assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
   // A completion on the timeout cycle takes priority over the timeout.
   assign failed   = done ? !good : ((state_q == StReq) && tmo_hit);

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      tmo_d    = tmo_q;
      gap_d    = gap_q;
      retry_d  = retry_q;
      temp_d   = temp_q;
      hum_d    = hum_q;
      valid_d  = 1'b0;
      stale_d  = stale_q;
      fault_d  = fault_q;
      fail_d   = fail_q;
      // Requests outside IDLE are dropped rather than queued.
      force_d  = force_read && (state_q == StIdle);

      unique case (state_q)
         StIdle: begin
            if (force_q || (period_q == PW'(PERIOD_CYCLES - 1))) begin
               state_d  = StReq;
               period_d = '0;
               tmo_d    = '0;
            end else begin
               period_d = period_q + PW'(1);
            end
         end
         StReq: begin
            if (good) begin
               state_d = StIdle;
               temp_d  = dht_temp_raw;
               hum_d   = dht_hum_raw;
               valid_d = 1'b1;
               stale_d = 1'b0;
               fault_d = 1'b0;
               retry_d = '0;
            end else if (failed) begin
               if (retry_q < RW'(MAX_RETRY)) begin
                  state_d = StBackoff;
                  retry_d = retry_q + RW'(1);
                  gap_d   = '0;
               end else begin
                  state_d = StFaultUpd;
                  fault_d = 1'b1;
                  stale_d = 1'b1;
                  retry_d = '0;
                  if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         StBackoff: begin
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
               state_d = StReq;
               tmo_d   = '0;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         StFaultUpd: state_d = StIdle;
         default:    state_d = StIdle;
      endcase

      dht_en_d = (state_d == StReq);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         period_q <= '0;
         tmo_q    <= '0;
         gap_q    <= '0;
         retry_q  <= '0;
         force_q  <= 1'b0;
         dht_en_q <= 1'b0;
         temp_q   <= 8'd0;
         hum_q    <= 8'd0;
         valid_q  <= 1'b0;
         stale_q  <= 1'b1;
         fault_q  <= 1'b0;
         fail_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         tmo_q    <= tmo_d;
         gap_q    <= gap_d;
         retry_q  <= retry_d;
         force_q  <= force_d;
         dht_en_q <= dht_en_d;
         temp_q   <= temp_d;
         hum_q    <= hum_d;
         valid_q  <= valid_d;
         stale_q  <= stale_d;
         fault_q  <= fault_d;
         fail_q   <= fail_d;
      end
   end

   assign dht_en       = dht_en_q;
   assign temperature  = temp_q;
   assign humidity     = hum_q;
   assign sample_valid = valid_q;
   assign data_stale   = stale_q;
   assign fault        = fault_q;
   assign fail_count   = fail_q;

endmodule

// File: tb/tb_dht_read_scheduler.sv
// Directed bench for dht_read_scheduler with a small hand-driven sensor-driver responder.
module tb_dht_read_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       force_read = 1'b0;
   logic       dht_data_ready = 1'b0;
   logic       dht_error = 1'b0;
   logic [7:0] dht_temp_raw = 8'd0;
   logic [7:0] dht_hum_raw = 8'd0;
   logic       dht_en;
   logic [7:0] temperature;
   logic [7:0] humidity;
   logic       sample_valid;
   logic       data_stale;
   logic       fault;
   logic [7:0] fail_count;

   int n_checks = 0;
   int n_errors = 0;

   dht_read_scheduler #(
      .PERIOD_CYCLES (20),
      .TIMEOUT_CYCLES(8),
      .GAP_CYCLES    (4),
      .MAX_RETRY     (2),
      .TEMP_MAX      (60),
      .HUM_MAX       (100)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .force_read    (force_read),
      .dht_en        (dht_en),
      .dht_data_ready(dht_data_ready),
      .dht_error     (dht_error),
      .dht_temp_raw  (dht_temp_raw),
      .dht_hum_raw   (dht_hum_raw),
      .temperature   (temperature),
      .humidity      (humidity),
      .sample_valid  (sample_valid),
      .data_stale    (data_stale),
      .fault         (fault),
      .fail_count    (fail_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count cycles until dht_en reaches the given level (bounded).
   task automatic wait_en(input logic level, input string tag, output int n);
      n = 0;
      while (dht_en !== level && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check_eq({tag, "_timeout"}, n, 0);
   endtask

   // Driver answer: wait, then a one-cycle completion strobe with the given payload.
   task automatic answer(input int delay, input logic err, input int t, input int h);
      repeat (delay) tick();
      dht_data_ready = 1'b1;
      dht_error      = err;
      dht_temp_raw   = 8'(t);
      dht_hum_raw    = 8'(h);
      tick();
      dht_data_ready = 1'b0;
      dht_error      = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_dht_en"}, int'(dht_en), 0);
      check_eq({tag, "_temp"}, int'(temperature), 0);
      check_eq({tag, "_hum"}, int'(humidity), 0);
      check_eq({tag, "_valid"}, int'(sample_valid), 0);
      check_eq({tag, "_stale"}, int'(data_stale), 1);
      check_eq({tag, "_fault"}, int'(fault), 0);
      check_eq({tag, "_fail_cnt"}, int'(fail_count), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tick();
      tick();
      check_reset_outputs("rst");
      rst_n = 1'b1;

      // 1: first scheduled read and a good answer
      wait_en(1'b1, "first_en", n);
      check_eq("first_read_delay", n, 20);
      answer(4, 1'b0, 23, 45);
      check_eq("s1_valid", int'(sample_valid), 1);
      check_eq("s1_temp", int'(temperature), 23);
      check_eq("s1_hum", int'(humidity), 45);
      check_eq("s1_stale", int'(data_stale), 0);
      check_eq("s1_fault", int'(fault), 0);
      tick();
      check_eq("s1_valid_one_cycle", int'(sample_valid), 0);
      wait_en(1'b1, "period", n);
      check_eq("s1_period", n + 1, 20);

      // 2: no answer at all -> three timed-out windows, then fault
      for (int a = 0; a < 3; a++) begin
         if (a > 0) begin
            wait_en(1'b1, "s2_gap", n);
            check_eq("s2_gap_len", n, 4);
         end
         wait_en(1'b0, "s2_win", n);
         check_eq("s2_window_len", n, 8);
      end
      check_eq("s2_fault", int'(fault), 1);
      check_eq("s2_stale", int'(data_stale), 1);
      check_eq("s2_fail_cnt", int'(fail_count), 1);
      check_eq("s2_temp_kept", int'(temperature), 23);
      check_eq("s2_hum_kept", int'(humidity), 45);

      // 3: checksum error then good answer
      wait_en(1'b1, "s3_en", n);
      answer(2, 1'b1, 0, 0);
      check_eq("s3_en_drop", int'(dht_en), 0);
      check_eq("s3_no_valid", int'(sample_valid), 0);
      wait_en(1'b1, "s3_gap", n);
      check_eq("s3_backoff_len", n, 4);
      answer(2, 1'b0, 5, 30);
      check_eq("s3_valid", int'(sample_valid), 1);
      check_eq("s3_temp", int'(temperature), 5);
      check_eq("s3_hum", int'(humidity), 30);
      check_eq("s3_fault", int'(fault), 0);
      check_eq("s3_stale", int'(data_stale), 0);
      check_eq("s3_fail_cnt", int'(fail_count), 1);

      // 4: implausible humidity on every attempt
      for (int a = 0; a < 3; a++) begin
         wait_en(1'b1, "s4_en", n);
         answer(1, 1'b0, 20, 120);
      end
      check_eq("s4_fault", int'(fault), 1);
      check_eq("s4_valid", int'(sample_valid), 0);
      check_eq("s4_hum_kept", int'(humidity), 30);
      check_eq("s4_temp_kept", int'(temperature), 5);
      check_eq("s4_fail_cnt", int'(fail_count), 2);

      // 5: on-demand read in IDLE, request during REQ dropped
      tick();
      repeat (3) tick();
      force_read = 1'b1;
      tick();
      force_read = 1'b0;
      check_eq("s5_force_lat1", int'(dht_en), 0);
      tick();
      check_eq("s5_force_lat2", int'(dht_en), 1);
      force_read = 1'b1;
      tick();
      force_read = 1'b0;
      answer(1, 1'b0, 30, 50);
      check_eq("s5_valid", int'(sample_valid), 1);
      check_eq("s5_temp", int'(temperature), 30);
      check_eq("s5_hum", int'(humidity), 50);
      wait_en(1'b1, "s5_next", n);
      check_eq("s5_no_queued_read", n, 20);

      // 6: asynchronous reset mid-REQ, then fail counter saturation
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int f = 1; f <= 256; f++) begin
         for (int a = 0; a < 3; a++) begin
            wait_en(1'b1, "s6_en", n);
            wait_en(1'b0, "s6_dis", n);
         end
         if (f == 1) check_eq("s6_fail_cnt_1", int'(fail_count), 1);
         if (f == 255) check_eq("s6_fail_cnt_255", int'(fail_count), 255);
         if (f == 256) check_eq("s6_fail_cnt_sat", int'(fail_count), 255);
      end
      check_eq("s6_fault", int'(fault), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
